// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package reg_file_mp_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;

    // Low bit index of slice idx in a vector of equal-width fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue, cleared on write.
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic                  write1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic                  issue,
    input  logic [ADDR_W-1:0]     issue_addr,
    output logic [2**ADDR_W-1:0]  pending
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Next state: writes clear first, then issue sets so issue wins on a collision.
    always_comb begin
        pending_d = pending_q;
        if (write0) begin
            pending_d[waddr0] = 1'b0;
        end
        if (write1) begin
            pending_d[waddr1] = 1'b0;
        end
        if (issue) begin
            pending_d[issue_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end
    end

    // Pending register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports,
// optional write-to-read bypass, optional hardwired zero register and a
// per-register pending scoreboard reported per read port.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [DATA_W-1:0]          IN0,
    input  logic [ADDR_W-1:0]          INADDRESS0,
    input  logic                       WRITE0,
    input  logic [DATA_W-1:0]          IN1,
    input  logic [ADDR_W-1:0]          INADDRESS1,
    input  logic                       WRITE1,
    input  logic [NUM_RD*ADDR_W-1:0]   OUTADDRESS,
    output logic [NUM_RD*DATA_W-1:0]   OUT,
    input  logic                       ISSUE,
    input  logic [ADDR_W-1:0]          ISSUEADDRESS,
    output logic [NUM_RD-1:0]          BUSY
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wr0_en;
    logic              wr1_en;

    // Writes aimed at a hardwired zero register are dropped entirely, which
    // also keeps them out of the bypass path.
    assign wr0_en = WRITE0 && !((ZERO_REG != 0) && (INADDRESS0 == '0));
    assign wr1_en = WRITE1 && !((ZERO_REG != 0) && (INADDRESS1 == '0));

    // Storage array; port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr0_en) begin
                regs_q[INADDRESS0] <= IN0;
            end
            if (wr1_en) begin
                regs_q[INADDRESS1] <= IN1;
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (CLK),
        .reset      (RESET),
        .write0     (WRITE0),
        .waddr0     (INADDRESS0),
        .write1     (WRITE1),
        .waddr1     (INADDRESS1),
        .issue      (ISSUE),
        .issue_addr (ISSUEADDRESS),
        .pending    (pending)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic              rd_busy;

        assign rd_addr = OUTADDRESS[slice_lo(k, ADDR_W) +: ADDR_W];

        // Read mux: array, then bypass (port 1 over port 0), then zero-register override.
        always_comb begin
            rd_data = regs_q[rd_addr];
            rd_busy = pending[rd_addr];
            if (BYPASS != 0) begin
                if (wr0_en && (rd_addr == INADDRESS0)) begin
                    rd_data = IN0;
                    rd_busy = 1'b0;
                end
                if (wr1_en && (rd_addr == INADDRESS1)) begin
                    rd_data = IN1;
                    rd_busy = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
        end

        assign OUT[slice_lo(k, DATA_W) +: DATA_W] = rd_data;
        assign BUSY[k]                            = rd_busy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: stimulus pushes expected read data/busy per port into a
// queue each cycle; a monitor on the falling edge pops and compares.
// DUT a: BYPASS=1, NUM_RD=2. DUT b: BYPASS=0, NUM_RD=3. Both share write/issue/reset.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in0, in1;
    logic [4:0]  waddr0, waddr1, iaddr;
    logic        wr0, wr1, issue;
    logic [9:0]  a_raddr;
    logic [63:0] a_out;
    logic [1:0]  a_busy;
    logic [14:0] b_raddr;
    logic [95:0] b_out;
    logic [2:0]  b_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .CLK(clk), .RESET(reset),
        .IN0(in0), .INADDRESS0(waddr0), .WRITE0(wr0),
        .IN1(in1), .INADDRESS1(waddr1), .WRITE1(wr1),
        .OUTADDRESS(a_raddr), .OUT(a_out),
        .ISSUE(issue), .ISSUEADDRESS(iaddr), .BUSY(a_busy)
    );

    reg_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .CLK(clk), .RESET(reset),
        .IN0(in0), .INADDRESS0(waddr0), .WRITE0(wr0),
        .IN1(in1), .INADDRESS1(waddr1), .WRITE1(wr1),
        .OUTADDRESS(b_raddr), .OUT(b_out),
        .ISSUE(issue), .ISSUEADDRESS(iaddr), .BUSY(b_busy)
    );

    // Monitor: compare every queued expectation against current outputs.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act_d;
            logic        act_b;
            e = sb_q.pop_front();
            if (e.dut == 0) begin
                act_d = a_out[e.port*32 +: 32];
                act_b = a_busy[e.port];
            end else begin
                act_d = b_out[e.port*32 +: 32];
                act_b = b_busy[e.port];
            end
            checks++;
            if (act_d !== e.data) begin
                errors++;
                $display("FAIL %s dut%0d port%0d OUT: got %h expected %h",
                         e.name, e.dut, e.port, act_d, e.data);
            end
            checks++;
            if (act_b !== e.busy) begin
                errors++;
                $display("FAIL %s dut%0d port%0d BUSY: got %b expected %b",
                         e.name, e.dut, e.port, act_b, e.busy);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr0   = 1'b0;
        wr1   = 1'b0;
        issue = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1,
                      input logic [4:0] b0, input logic [4:0] b1, input logic [4:0] b2);
        a_raddr = {a1, a0};
        b_raddr = {b2, b1, b0};
    endtask

    task automatic w0(input logic [4:0] a, input logic [31:0] d);
        wr0 = 1'b1; waddr0 = a; in0 = d;
    endtask

    task automatic w1(input logic [4:0] a, input logic [31:0] d);
        wr1 = 1'b1; waddr1 = a; in1 = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue = 1'b1; iaddr = a;
    endtask

    task automatic ex(input int dut, input int port, input logic [31:0] d,
                      input logic b, input string name);
        exp_t e;
        e.dut = dut; e.port = port; e.data = d; e.busy = b; e.name = name;
        sb_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; wr0 = 1'b0; wr1 = 1'b0; issue = 1'b0;
        in0 = '0; in1 = '0; waddr0 = '0; waddr1 = '0; iaddr = '0;
        a_raddr = '0; b_raddr = '0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset state.
        next_cycle();
        rd(5, 9, 5, 9, 1);
        ex(0, 0, 32'h0, 1'b0, "rst_r5"); ex(0, 1, 32'h0, 1'b0, "rst_r9");
        ex(1, 0, 32'h0, 1'b0, "rst_r5"); ex(1, 1, 32'h0, 1'b0, "rst_r9");
        ex(1, 2, 32'h0, 1'b0, "rst_r1");

        // Write r5 via port 0: bypass on a, old value on b.
        next_cycle();
        w0(5, 32'hDEADBEEF);
        rd(5, 6, 5, 5, 6);
        ex(0, 0, 32'hDEADBEEF, 1'b0, "byp_r5"); ex(0, 1, 32'h0, 1'b0, "byp_r6");
        ex(1, 0, 32'h0, 1'b0, "nobyp_r5"); ex(1, 1, 32'h0, 1'b0, "nobyp_r5");

        next_cycle();
        rd(5, 5, 5, 5, 5);
        ex(0, 0, 32'hDEADBEEF, 1'b0, "arr_r5"); ex(0, 1, 32'hDEADBEEF, 1'b0, "arr_r5");
        ex(1, 0, 32'hDEADBEEF, 1'b0, "arr_r5"); ex(1, 1, 32'hDEADBEEF, 1'b0, "arr_r5");
        ex(1, 2, 32'hDEADBEEF, 1'b0, "arr_r5");

        // Both ports write r7: port 1 wins.
        next_cycle();
        w0(7, 32'h11); w1(7, 32'h22);
        rd(7, 5, 7, 7, 5);
        ex(0, 0, 32'h22, 1'b0, "dual_byp_r7"); ex(0, 1, 32'hDEADBEEF, 1'b0, "dual_r5");
        ex(1, 0, 32'h0, 1'b0, "dual_nobyp_r7");

        next_cycle();
        rd(7, 7, 7, 7, 7);
        ex(0, 1, 32'h22, 1'b0, "dual_arr_r7");
        ex(1, 2, 32'h22, 1'b0, "dual_arr_r7");

        // Zero register: write and issue both ignored.
        next_cycle();
        w0(0, 32'hFFFFFFFF); iss(0);
        rd(0, 0, 0, 0, 0);
        ex(0, 0, 32'h0, 1'b0, "r0_same"); ex(1, 0, 32'h0, 1'b0, "r0_same");

        next_cycle();
        rd(0, 0, 0, 0, 0);
        ex(0, 1, 32'h0, 1'b0, "r0_next"); ex(1, 1, 32'h0, 1'b0, "r0_next");

        // Scoreboard on r3.
        next_cycle();
        iss(3);
        rd(3, 3, 3, 3, 3);
        ex(0, 0, 32'h0, 1'b0, "iss_r3_same");

        next_cycle();
        iss(3); w0(3, 32'h5);
        rd(3, 3, 3, 3, 3);
        ex(0, 0, 32'h5, 1'b0, "iss_wr_byp_r3");
        ex(1, 0, 32'h0, 1'b1, "iss_wr_nobyp_r3");

        next_cycle();
        rd(3, 3, 3, 3, 3);
        ex(0, 0, 32'h5, 1'b1, "iss_wins_r3"); ex(1, 1, 32'h5, 1'b1, "iss_wins_r3");

        next_cycle();
        w1(3, 32'h33);
        rd(3, 7, 3, 3, 3);
        ex(0, 0, 32'h33, 1'b0, "w1_clr_byp_r3"); ex(0, 1, 32'h22, 1'b0, "r7_hold");
        ex(1, 2, 32'h5, 1'b1, "w1_clr_nobyp_r3");

        next_cycle();
        rd(3, 3, 3, 3, 3);
        ex(0, 1, 32'h33, 1'b0, "r3_cleared"); ex(1, 0, 32'h33, 1'b0, "r3_cleared");

        // Load r8, make r9 pending, then reset with a competing write.
        next_cycle();
        iss(9); w1(8, 32'h88);
        rd(9, 8, 9, 8, 8);
        ex(0, 0, 32'h0, 1'b0, "pre_r9"); ex(0, 1, 32'h88, 1'b0, "pre_byp_r8");
        ex(1, 1, 32'h0, 1'b0, "pre_nobyp_r8");

        next_cycle();
        reset = 1'b1; w0(9, 32'h9);
        rd(9, 8, 9, 8, 3);
        ex(0, 0, 32'h9, 1'b0, "rst_byp_r9"); ex(0, 1, 32'h88, 1'b0, "rst_arr_r8");
        ex(1, 0, 32'h0, 1'b1, "rst_pend_r9"); ex(1, 1, 32'h88, 1'b0, "rst_arr_r8");
        ex(1, 2, 32'h33, 1'b0, "rst_arr_r3");

        next_cycle();
        rd(9, 8, 9, 8, 5);
        ex(0, 0, 32'h0, 1'b0, "post_rst_r9"); ex(0, 1, 32'h0, 1'b0, "post_rst_r8");
        ex(1, 0, 32'h0, 1'b0, "post_rst_r9"); ex(1, 1, 32'h0, 1'b0, "post_rst_r8");
        ex(1, 2, 32'h0, 1'b0, "post_rst_r5");

        next_cycle();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
